// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard unit signal bundle.
// master = pipeline side (drives register addresses and stage info),
// slave  = hazard unit (drives stall/flush/forward controls and counters).
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;
    logic [REG_AW-1:0] rs1_e;
    logic [REG_AW-1:0] rs2_e;
    logic [REG_AW-1:0] rd_e;
    logic              result_src_e_0;
    logic              long_e;
    logic              pc_src_e;
    logic [REG_AW-1:0] rd_m;
    logic              regwrite_m;
    logic [REG_AW-1:0] rd_w;
    logic              regwrite_w;
    logic              stall_f;
    logic              stall_d;
    logic              stall_e;
    logic              flush_d;
    logic              flush_e;
    logic              flush_m;
    logic [1:0]        forward_operand_a_e;
    logic [1:0]        forward_operand_b_e;
    logic              long_busy;
    logic [CNT_W-1:0]  perf_stall_cnt;
    logic [CNT_W-1:0]  perf_flush_cnt;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e_0, long_e, pc_src_e,
               rd_m, regwrite_m, rd_w, regwrite_w,
        input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
               forward_operand_a_e, forward_operand_b_e, long_busy,
               perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e_0, long_e, pc_src_e,
               rd_m, regwrite_m, rd_w, regwrite_w,
        output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
               forward_operand_a_e, forward_operand_b_e, long_busy,
               perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard unit for the five-stage RV32 pipeline.
// EX-operand forwarding, load-use stall, branch flush and a countdown FSM
// that holds the front of the pipe while a multi-cycle (mul/div) op sits in EX.
// Optional feature: define HAZARD_PERF_EN to build saturating stall/flush
// performance counters; otherwise both counter outputs are tied to zero.
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LONG_LAT = 4,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        reset,
    hazard_ctrl_if.slave hz
);
    localparam int CNT_BITS = (LONG_LAT > 1) ? $clog2(LONG_LAT) : 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_LONG = 1'b1;

    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_LOAD = (LONG_LAT > 2) ? CNT_BITS'(LONG_LAT - 2) : CNT_ZERO;
    localparam logic [REG_AW-1:0]   REG_ZERO = {REG_AW{1'b0}};

    // Forward select for one EX source: MEM result wins over WB result; x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              wr_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              wr_w
    );
        logic [1:0] sel;
        if (wr_m && (rd_m == rs) && (rd_m != REG_ZERO)) begin
            sel = 2'b10;
        end else if (wr_w && (rd_w == rs) && (rd_w != REG_ZERO)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    logic [0:0]          state_r;
    logic [0:0]          state_nxt_s;
    logic [CNT_BITS-1:0] cnt_r;
    logic [CNT_BITS-1:0] cnt_nxt_s;
    logic                load_use_s;
    logic                stall_f_s;
    logic                stall_d_s;
    logic                stall_e_s;
    logic                flush_d_s;
    logic                flush_e_s;
    logic                flush_m_s;
    logic [1:0]          fwd_a_s;
    logic [1:0]          fwd_b_s;
    logic                long_busy_s;

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        load_use_s = hz.result_src_e_0 && (hz.rd_e != REG_ZERO) &&
                     ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
    end

    // Hazard decisions and FSM next state; all controls forced low while in reset.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_f_s   = 1'b0;
        stall_d_s   = 1'b0;
        stall_e_s   = 1'b0;
        flush_d_s   = 1'b0;
        flush_e_s   = 1'b0;
        flush_m_s   = 1'b0;
        fwd_a_s     = 2'b00;
        fwd_b_s     = 2'b00;
        long_busy_s = 1'b0;
        if (reset) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            fwd_a_s = fwd_sel(hz.rs1_e, hz.rd_m, hz.regwrite_m, hz.rd_w, hz.regwrite_w);
            fwd_b_s = fwd_sel(hz.rs2_e, hz.rd_m, hz.regwrite_m, hz.rd_w, hz.regwrite_w);
            case (state_r)
                ST_RUN: begin
                    if (hz.pc_src_e) begin
                        flush_d_s = 1'b1;
                        flush_e_s = 1'b1;
                    end else if (hz.long_e && (LONG_LAT > 1)) begin
                        stall_f_s = 1'b1;
                        stall_d_s = 1'b1;
                        stall_e_s = 1'b1;
                        flush_m_s = 1'b1;
                        if (LONG_LAT > 2) begin
                            state_nxt_s = ST_LONG;
                            cnt_nxt_s   = CNT_LOAD;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else if (load_use_s) begin
                        stall_f_s = 1'b1;
                        stall_d_s = 1'b1;
                        flush_e_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_LONG: begin
                    // EX is owned by the long op: branch, new long op and load-use wait.
                    stall_f_s   = 1'b1;
                    stall_d_s   = 1'b1;
                    stall_e_s   = 1'b1;
                    flush_m_s   = 1'b1;
                    long_busy_s = 1'b1;
                    if (cnt_r <= CNT_ONE) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // FSM state and countdown registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RUN;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign hz.stall_f             = stall_f_s;
    assign hz.stall_d             = stall_d_s;
    assign hz.stall_e             = stall_e_s;
    assign hz.flush_d             = flush_d_s;
    assign hz.flush_e             = flush_e_s;
    assign hz.flush_m             = flush_m_s;
    assign hz.forward_operand_a_e = fwd_a_s;
    assign hz.forward_operand_b_e = fwd_b_s;
    assign hz.long_busy           = long_busy_s;

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] PERF_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PERF_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] perf_stall_r;
    logic [CNT_W-1:0] perf_flush_r;

    // Saturating counters: stalled decode cycles and taken-branch flushes in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_r <= {CNT_W{1'b0}};
            perf_flush_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_d_s && (perf_stall_r != PERF_MAX)) begin
                perf_stall_r <= perf_stall_r + PERF_ONE;
            end
            if (flush_d_s && (perf_flush_r != PERF_MAX)) begin
                perf_flush_r <= perf_flush_r + PERF_ONE;
            end
        end
    end

    assign hz.perf_stall_cnt = reset ? {CNT_W{1'b0}} : perf_stall_r;
    assign hz.perf_flush_cnt = reset ? {CNT_W{1'b0}} : perf_flush_r;
`else
    assign hz.perf_stall_cnt = {CNT_W{1'b0}};
    assign hz.perf_flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with hand-computed expectations, checked by
// a scoreboard. DUT A: RV32I, LONG_LAT=4, CNT_W=4. DUT B: RV32E, LONG_LAT=8.
module tb_hazard_ctrl;
    typedef struct packed {
        logic       sf, sd, se, fd, fe, fm;
        logic [1:0] fa, fb;
        logic       lb;
    } exp_t;

    typedef struct packed {
        logic       reset;
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
        logic       ld, long_e, pc;
        logic [4:0] rd_m;
        logic       rw_m;
        logic [4:0] rd_w;
        logic       rw_w;
    } stim_t;

    typedef struct packed {
        exp_t        a;
        exp_t        b;
        logic [31:0] psa, pfa, psb, pfb;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;
    logic vec_v = 1'b0;
    sb_t  sb_q[$];

    logic [31:0] ma_s = 32'd0, ma_f = 32'd0, mb_s = 32'd0, mb_f = 32'd0;
    exp_t E0, E_LU, E_BR, E_LG, E_LB;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  hif_a ();
    hazard_ctrl_if #(.REG_AW(4), .CNT_W(32)) hif_b ();

    hazard_ctrl #(.REG_AW(5), .LONG_LAT(4), .CNT_W(4)) dut_a (
        .clk(clk), .reset(rst), .hz(hif_a.slave)
    );
    hazard_ctrl #(.REG_AW(4), .LONG_LAT(8), .CNT_W(32)) dut_b (
        .clk(clk), .reset(rst), .hz(hif_b.slave)
    );

    function automatic exp_t mk(input logic sf, input logic sd, input logic se, input logic fd,
                                input logic fe, input logic fm, input logic [1:0] fa,
                                input logic [1:0] fb, input logic lb);
        exp_t e;
        e.sf = sf; e.sd = sd; e.se = se; e.fd = fd; e.fe = fe; e.fm = fm;
        e.fa = fa; e.fb = fb; e.lb = lb;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        rst = s.reset;
        hif_a.rs1_d = s.rs1_d;       hif_b.rs1_d = s.rs1_d[3:0];
        hif_a.rs2_d = s.rs2_d;       hif_b.rs2_d = s.rs2_d[3:0];
        hif_a.rs1_e = s.rs1_e;       hif_b.rs1_e = s.rs1_e[3:0];
        hif_a.rs2_e = s.rs2_e;       hif_b.rs2_e = s.rs2_e[3:0];
        hif_a.rd_e  = s.rd_e;        hif_b.rd_e  = s.rd_e[3:0];
        hif_a.rd_m  = s.rd_m;        hif_b.rd_m  = s.rd_m[3:0];
        hif_a.rd_w  = s.rd_w;        hif_b.rd_w  = s.rd_w[3:0];
        hif_a.result_src_e_0 = s.ld; hif_b.result_src_e_0 = s.ld;
        hif_a.long_e   = s.long_e;   hif_b.long_e   = s.long_e;
        hif_a.pc_src_e = s.pc;       hif_b.pc_src_e = s.pc;
        hif_a.regwrite_m = s.rw_m;   hif_b.regwrite_m = s.rw_m;
        hif_a.regwrite_w = s.rw_w;   hif_b.regwrite_w = s.rw_w;
    endtask

    // One clock of stimulus; expected outputs (and expected counters derived
    // from the expected stall_d/flush_d pattern) go into the scoreboard.
    task automatic cyc(input stim_t s, input exp_t ea, input exp_t eb);
        sb_t e;
        @(posedge clk);
        #1;
        drive(s);
        e.a = ea;
        e.b = eb;
`ifdef HAZARD_PERF_EN
        e.psa = s.reset ? 32'd0 : ma_s;
        e.pfa = s.reset ? 32'd0 : ma_f;
        e.psb = s.reset ? 32'd0 : mb_s;
        e.pfb = s.reset ? 32'd0 : mb_f;
`else
        e.psa = 32'd0; e.pfa = 32'd0; e.psb = 32'd0; e.pfb = 32'd0;
`endif
        if (s.reset) begin
            ma_s = 32'd0; ma_f = 32'd0; mb_s = 32'd0; mb_f = 32'd0;
        end else begin
            if (ea.sd && ma_s != 32'd15) ma_s = ma_s + 32'd1;
            if (ea.fd && ma_f != 32'd15) ma_f = ma_f + 32'd1;
            if (eb.sd) mb_s = mb_s + 32'd1;
            if (eb.fd) mb_f = mb_f + 32'd1;
        end
        sb_q.push_back(e);
        vec_v = 1'b1;
    endtask

    // Monitor: pops one expectation per presented cycle and compares both DUTs.
    always @(negedge clk) begin
        sb_t  e;
        exp_t act_a, act_b;
        if (vec_v) begin
            cyc_no = cyc_no + 1;
            checks = checks + 1;
            if (sb_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL scoreboard_empty cycle %0d", cyc_no);
            end else begin
                e = sb_q.pop_front();
                act_a = {hif_a.stall_f, hif_a.stall_d, hif_a.stall_e, hif_a.flush_d, hif_a.flush_e,
                         hif_a.flush_m, hif_a.forward_operand_a_e, hif_a.forward_operand_b_e, hif_a.long_busy};
                act_b = {hif_b.stall_f, hif_b.stall_d, hif_b.stall_e, hif_b.flush_d, hif_b.flush_e,
                         hif_b.flush_m, hif_b.forward_operand_a_e, hif_b.forward_operand_b_e, hif_b.long_busy};
                if (act_a !== e.a) begin
                    errors = errors + 1;
                    $display("FAIL ctrl_a cycle %0d got %b want %b (sf sd se fd fe fm fa fb lb)", cyc_no, act_a, e.a);
                end
                checks = checks + 1;
                if (act_b !== e.b) begin
                    errors = errors + 1;
                    $display("FAIL ctrl_b cycle %0d got %b want %b (sf sd se fd fe fm fa fb lb)", cyc_no, act_b, e.b);
                end
                checks = checks + 1;
                if ({28'd0, hif_a.perf_stall_cnt} !== e.psa || {28'd0, hif_a.perf_flush_cnt} !== e.pfa) begin
                    errors = errors + 1;
                    $display("FAIL perf_a cycle %0d got stall %0d flush %0d want stall %0d flush %0d",
                             cyc_no, hif_a.perf_stall_cnt, hif_a.perf_flush_cnt, e.psa, e.pfa);
                end
                checks = checks + 1;
                if (hif_b.perf_stall_cnt !== e.psb || hif_b.perf_flush_cnt !== e.pfb) begin
                    errors = errors + 1;
                    $display("FAIL perf_b cycle %0d got stall %0d flush %0d want stall %0d flush %0d",
                             cyc_no, hif_b.perf_stall_cnt, hif_b.perf_flush_cnt, e.psb, e.pfb);
                end
            end
        end
    end

    initial begin
        stim_t s;
        E0   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        E_LU = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        E_BR = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        E_LG = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        E_LB = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1);
        s = '0;
        s.reset = 1'b1;
        drive(s);

        // reset, then first cycle after it
        cyc(s, E0, E0);
        cyc(s, E0, E0);
        s = '0; cyc(s, E0, E0);

        // forwarding
        s = '0; s.rw_m = 1'b1; s.rd_m = 5'd5; s.rs1_e = 5'd5;
        cyc(s, mk(0,0,0,0,0,0,2'b10,2'b00,0), mk(0,0,0,0,0,0,2'b10,2'b00,0));
        s.rw_m = 1'b0; s.rw_w = 1'b1; s.rd_w = 5'd5;
        cyc(s, mk(0,0,0,0,0,0,2'b01,2'b00,0), mk(0,0,0,0,0,0,2'b01,2'b00,0));
        s = '0; s.rw_m = 1'b1; s.rw_w = 1'b1;
        cyc(s, E0, E0);
        s = '0; s.rw_m = 1'b1; s.rw_w = 1'b1; s.rd_m = 5'd6; s.rd_w = 5'd6; s.rs2_e = 5'd6;
        cyc(s, mk(0,0,0,0,0,0,2'b00,2'b10,0), mk(0,0,0,0,0,0,2'b00,2'b10,0));
        s = '0; s.rw_m = 1'b1; s.rd_m = 5'd6; s.rw_w = 1'b1; s.rd_w = 5'd3; s.rs1_e = 5'd3; s.rs2_e = 5'd6;
        cyc(s, mk(0,0,0,0,0,0,2'b01,2'b10,0), mk(0,0,0,0,0,0,2'b01,2'b10,0));
        s.rw_m = 1'b0;
        cyc(s, mk(0,0,0,0,0,0,2'b01,2'b00,0), mk(0,0,0,0,0,0,2'b01,2'b00,0));

        // load-use
        s = '0; s.ld = 1'b1; s.rd_e = 5'd7; s.rs2_d = 5'd7; cyc(s, E_LU, E_LU);
        s = '0; cyc(s, E0, E0);
        s = '0; s.ld = 1'b1; cyc(s, E0, E0);
        s = '0; s.ld = 1'b1; s.rd_e = 5'd7; s.rs1_d = 5'd7; cyc(s, E_LU, E_LU);
        s.ld = 1'b0; cyc(s, E0, E0);

        // taken branch wins over load-use
        s = '0; s.pc = 1'b1; s.ld = 1'b1; s.rd_e = 5'd7; s.rs2_d = 5'd7; cyc(s, E_BR, E_BR);
        s = '0; cyc(s, E0, E0);

        // long op admitted at t, retrigger at t+4; branch/load-use ignored in LONG
        s = '0; s.long_e = 1'b1; cyc(s, E_LG, E_LG);
        s = '0; cyc(s, E_LB, E_LB);
        cyc(s, E_LB, E_LB);
        cyc(s, E0, E_LB);
        s.long_e = 1'b1; cyc(s, E_LG, E_LB);
        s = '0; s.pc = 1'b1; s.ld = 1'b1; s.rd_e = 5'd7; s.rs1_d = 5'd7; cyc(s, E_LB, E_LB);
        s = '0; s.rw_m = 1'b1; s.rd_m = 5'd2; s.rs1_e = 5'd2;
        cyc(s, mk(1,1,1,0,0,1,2'b10,2'b00,1), mk(1,1,1,0,0,1,2'b10,2'b00,1));
        s = '0; cyc(s, E0, E0);

        // reset in the middle of a long op, then a fresh full-length op
        s = '0; s.long_e = 1'b1; cyc(s, E_LG, E_LG);
        s = '0; cyc(s, E_LB, E_LB);
        s.reset = 1'b1; cyc(s, E0, E0);
        s = '0; cyc(s, E0, E0);
        s.long_e = 1'b1; cyc(s, E_LG, E_LG);
        s = '0;
        for (int k = 1; k <= 7; k++) begin
            cyc(s, (k <= 2) ? E_LB : E0, (k <= 6) ? E_LB : E0);
        end

        // long_e held high: continuous back-to-back ops, drives counter A to saturation
        s = '0; s.long_e = 1'b1;
        for (int k = 0; k < 21; k++) begin
            cyc(s, (k % 3 == 0) ? E_LG : E_LB, (k % 7 == 0) ? E_LG : E_LB);
        end
        s = '0;
        cyc(s, E0, E0);
        cyc(s, E0, E0);

        @(negedge clk);
        #1;
        vec_v = 1'b0;
        checks = checks + 1;
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain left %0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
